// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch sequencer
//
// Holds the PC. On a redirect it loads the next-PC mux output; otherwise it
// steps PC+4 after each fetched word. It keeps at most one instruction-memory
// request outstanding and passes each fetched word to decode over valid/ready.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect to a target that is not 4-byte aligned is ignored
//               and sets misalign_o. misalign_o stays set until the next
//               aligned redirect or rst.
//   undefined : the target's low two bits are forced to zero; misalign_o = 0.
//
// Ports
//   clk           in   1     clock, posedge
//   rst           in   1     synchronous active-high reset
//   next_pc_i     in   XLEN  redirect target
//   redirect_i    in   1     load next_pc_i into the PC
//   stall_i       in   1     hold the fetch pipeline
//   imem_req_o    out  1     instruction memory request
//   imem_addr_o   out  XLEN  fetch address (PC while requesting, else 0)
//   imem_rvalid_i in   1     memory response valid
//   imem_rdata_i  in   32    memory response word
//   if_valid_o    out  1     instruction valid toward decode
//   if_ready_i    in   1     decode accepts
//   if_instr_o    out  32    fetched instruction
//   if_pc_o       out  XLEN  PC of if_instr_o
//   misalign_o    out  1     misaligned-redirect flag

module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            redirect_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;

  logic            take_redirect;
  logic [XLEN-1:0] redirect_pc;

  assign redirect_pc = {next_pc_i[XLEN-1:2], 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  logic mis_q;

  assign misaligned    = |next_pc_i[1:0];
  // A misaligned target is dropped entirely: pc and state keep going as if
  // no redirect had been requested.
  assign take_redirect = redirect_i & ~misaligned;
  assign misalign_o    = mis_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (redirect_i) begin
      mis_q <= misaligned;
    end
  end
`else
  logic unused_low_bits;

  assign unused_low_bits = ^next_pc_i[1:0];
  assign take_redirect   = redirect_i;
  assign misalign_o      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;

    case (state_q)
      S_IDLE: begin
        if (take_redirect) begin
          pc_d = redirect_pc;
        end
        if (!stall_i) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (take_redirect) begin
          // Without a response in this cycle the request is still in flight
          // at the memory, so its word must be swallowed in DRAIN.
          pc_d    = redirect_pc;
          state_d = imem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (take_redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end else if (if_ready_i && !stall_i) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (take_redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_rvalid_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = imem_req_o ? pc_q : '0;
  assign if_valid_o  = valid_q;
  assign if_instr_o  = instr_q;
  assign if_pc_o     = ifpc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized scoreboard bench for pc_fetch_unit

module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc_i;
  logic        redirect_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc_i     (next_pc_i),
    .redirect_i    (redirect_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .misalign_o    (misalign_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected stream of PCs decode should accept, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_cur;
  logic        exp_mis_cur;
  logic        chk_reset;
  logic        run_done;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic redirect_taken(input logic req, input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return req && (t[1:0] == 2'b00);
`else
    return req;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus and reference model: drives inputs #1 after each posedge and
  // advances the architectural view (next PC decode should see, misalign flag).
  initial begin
    logic [31:0] m_pc;
    logic        m_mis;
    logic        pending;
    logic        stale;
    logic [31:0] paddr;
    int          cnt;
    int          rst_left;
    int          idle;
    logic        abort;
    logic        eff;
    logic        acc;
    logic [31:0] t;

    rst = 1'b1; next_pc_i = '0; redirect_i = 1'b0; stall_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; if_ready_i = 1'b0;
    run_done = 1'b0; chk_reset = 1'b0; exp_addr_cur = RESET_PC; exp_mis_cur = 1'b0;
    m_pc = RESET_PC; m_mis = 1'b0; exp_q.delete(); exp_q.push_back(RESET_PC);
    pending = 1'b0; stale = 1'b0; paddr = '0; cnt = 0; rst_left = 2; idle = 0; abort = 1'b0;

    for (int cyc = 0; cyc < 5000 && !abort; cyc++) begin
      @(posedge clk);
      #1;
      chk_reset    = rst;
      exp_addr_cur = m_pc;
      exp_mis_cur  = m_mis;

      redirect_i = ($urandom_range(0, 99) < 8);
      stall_i    = ($urandom_range(0, 99) < 20);
      if_ready_i = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 5))
        0: t = $urandom & 32'hFFFF_FFFC;
        1: t = $urandom;
        2: t = 32'hFFFF_FFFC;
        3: t = 32'h1234_5678;
        4: t = 32'h0000_007A;
        default: t = 32'h0000_0080;
      endcase
      next_pc_i    = t;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;

      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        rst_left--;
        rst     = 1'b1;
        stale   = stale | pending;
        pending = 1'b0;
        m_pc    = RESET_PC;
        m_mis   = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        idle    = 0;
        continue;
      end
      rst = 1'b0;

      // Memory: one response per request, 1..4 cycles after it is first seen.
      // A request aborted by reset produces a stale response in the first
      // cycle after reset, which the fetch unit must ignore.
      if (stale) begin
        imem_rvalid_i = 1'b1;
        stale = 1'b0;
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pending = 1'b0;
        end
      end else if (imem_req_o) begin
        pending = 1'b1;
        paddr   = imem_addr_o;
        cnt     = $urandom_range(1, 4);
      end

      eff = redirect_taken(redirect_i, t);
      acc = if_valid_o && if_ready_i && !stall_i && !eff;
      if (eff) begin
        m_pc = {t[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back(m_pc);
      end else if (acc) begin
        m_pc = m_pc + 32'd4;
        exp_q.push_back(m_pc);
      end
`ifdef PC_MISALIGN_TRAP_EN
      if (redirect_i) m_mis = (t[1:0] != 2'b00);
`endif

      if (eff || acc) idle = 0;
      else idle++;
      if (idle > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL progress_timeout: got no delivery for %0d cycles expected progress", idle);
        abort = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    run_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every
  // accepted handshake and checks request address and flag every cycle.
  always @(negedge clk) begin
    if (run_done !== 1'b1) begin
      if (chk_reset) begin
        chk("reset_ctl", {29'b0, imem_req_o, if_valid_o, misalign_o}, 32'h0);
        chk("reset_addr", imem_addr_o, 32'h0);
        chk("reset_instr", if_instr_o, 32'h0);
        chk("reset_pc", if_pc_o, 32'h0);
      end
      if (imem_req_o) chk("fetch_addr", imem_addr_o, exp_addr_cur);
      chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis_cur});
      if (!rst && if_valid_o && if_ready_i && !stall_i && !redirect_taken(redirect_i, next_pc_i)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_delivery: got pc %h expected no instruction", if_pc_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("if_pc", if_pc_o, e);
          chk("if_instr", if_instr_o, mem_word(e));
        end
      end
    end
  end

endmodule
